mvm_accum_obuf: RTL
===================

// Module: mvm_accum_obuf
// PURPOSE
// Output stage downstream of the MVM controller. Consumes per-cycle signed partial products
// from the datapath along with the row-framing flags accum_first / accum_last.
// Accumulates each row into a dot-product result and queues completed results in a small
// first-word-fall-through (FWFT) FIFO, read out with a valid/ready handshake.
// Exports almost_full so the controller can stall, plus sticky error flags.
// PARAMETERS
// IWIDTH      16  signed partial-product width (idata)
// OWIDTH      24  signed accumulator/result width; must be >= IWIDTH
// FIFO_DEPTH  4   result FIFO entries; power of 2, >= 2
// PORTS
// clk          in   1                   clock, all logic on posedge
// rst          in   1                   synchronous, active-low reset (0 = reset)
// ivalid       in   1                   idata/flags valid this cycle (a "beat")
// idata        in   IWIDTH              signed partial product
// accum_first  in   1                   beat is first of a row; qualified by ivalid
// accum_last   in   1                   beat is last of a row; qualified by ivalid
// odata        out  OWIDTH              FIFO head result; 0 when FIFO empty
// ovalid       out  1                   FIFO non-empty
// oready       in   1                   consumer accepts odata; pop on ovalid&&oready
// count        out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
// almost_full  out  1                   count >= FIFO_DEPTH-1
// overflow     out  1                   sticky: a completed result was dropped (FIFO full)
// seq_err      out  1                   sticky: framing violation
// BEHAVIOUR
// - Reset (rst==0 at posedge) clears everything, including mid-row: acc=0, FSM=IDLE,
//   FIFO empty, count=0, ovalid=0, odata=0, almost_full=0, overflow=0, seq_err=0.
// - The partial sum of any in-flight row is lost on reset.
// - Arithmetic: sum = (FSM==ACC && !accum_first ? acc : 0) + sext(idata).
//   Computed modulo 2^OWIDTH (wraps); no saturation.
// - FSM IDLE:
//     beat with first && !last  -> acc<=sum, go to ACC.
//     beat with first && last   -> push sum, stay IDLE.
//     beat without first        -> ignored, set seq_err.
// - FSM ACC:
//     beat without first        -> acc<=sum; if last, push sum and go to IDLE.
//     beat with first           -> restart: set seq_err, discard acc, then act as IDLE
//                                  with first.
// - No beat (ivalid=0): acc and FSM state hold; flags are ignored.
// - Push timing: write on the posedge of the last beat.
//   With an empty FIFO, ovalid=1 and odata=result in the following cycle (1-cycle latency).
// - FIFO is FWFT; results come out in row order.
//   pop = ovalid && oready; push and pop in the same cycle are both honoured.
// - Push while full without a same-cycle pop: result dropped, set overflow, FIFO unchanged.
// - Push while full with a same-cycle pop: accepted; count unchanged.
// - Pop with an empty FIFO: no effect.
// - count, almost_full, ovalid: registered from FIFO state; valid in the cycle after each edge.
// TESTING (bench: IWIDTH=16, OWIDTH=20, FIFO_DEPTH=4)
// 1. Row 5,-2,7 (first on beat0, last on beat2), oready=1
//    -> next cycle ovalid=1, odata=10 for one cycle; seq_err=0.
// 2. Single-beat rows (first&last) 32767 then -32768
//    -> odata 20'h07FFF, then 20'hF8000.
// 3. One row of 32 beats of 32767
//    -> odata=20'hFFFE0 (wrap), overflow=0.
// 4. oready=0; five single-beat rows 1..5
//    -> almost_full=1 after 3rd push; 5th dropped, overflow=1.
//    Then oready=1 -> drains 1,2,3,4; ovalid=0 after.
// 5. Beat without first in IDLE -> no push, seq_err=1.
//    Row 1,2 interrupted by first=9, then last=1 -> single result 10.
// 6. rst=0 after two beats of a row
//    -> all outputs 0 next cycle; a following row 3,4 yields 7.

Source files
------------

// File: rtl/mvm_accum_obuf.sv
`default_nettype none
// ============================================================================
// Module   : mvm_accum_obuf
// Function : Row accumulator for MVM partial products feeding a FWFT result FIFO.
// Revision : 1.0
// ============================================================================
module mvm_accum_obuf #(
    parameter int IWIDTH     = 16,
    parameter int OWIDTH     = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ivalid,
    input  logic [IWIDTH-1:0]             idata,
    input  logic                          accum_first,
    input  logic                          accum_last,
    output logic [OWIDTH-1:0]             odata,
    output logic                          ovalid,
    input  logic                          oready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          almost_full,
    output logic                          overflow,
    output logic                          seq_err
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_lvl = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_af_lvl   = c_cnt_w'(FIFO_DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    state_t               r_state;
    logic [OWIDTH-1:0]    r_acc;
    logic                 r_seq_err;

    logic [OWIDTH-1:0]    r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wptr;
    logic [c_ptr_w-1:0]   r_rptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_ovalid;
    logic                 r_almost_full;
    logic                 r_overflow;

    logic [OWIDTH-1:0]    w_sext;
    logic                 w_cont;
    logic [OWIDTH-1:0]    w_sum;
    logic                 w_row_beat;
    logic                 w_row_done;
    logic                 w_seq_viol;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push_ok;
    logic [c_cnt_w-1:0]   w_count_nxt;

    // A first beat always starts a fresh row, discarding any partial sum.
    assign w_sext     = OWIDTH'($signed(idata));
    assign w_cont     = (r_state == ST_ACC) && !accum_first;
    assign w_sum      = (w_cont ? r_acc : '0) + w_sext;
    assign w_row_beat = ivalid && (accum_first || (r_state == ST_ACC));
    assign w_row_done = w_row_beat && accum_last;
    assign w_seq_viol = ivalid && (accum_first ? (r_state == ST_ACC) : (r_state == ST_IDLE));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_seq_err <= 1'b0;
        end else begin
            if (w_seq_viol) begin
                r_seq_err <= 1'b1;
            end
            if (w_row_beat) begin
                r_acc   <= w_sum;
                r_state <= accum_last ? ST_IDLE : ST_ACC;
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_full    = (r_count == c_full_lvl);
    assign w_pop     = r_ovalid && oready;
    assign w_push_ok = w_row_done && (!w_full || w_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop})
            2'b10:   w_count_nxt = r_count + c_cnt_one;
            2'b01:   w_count_nxt = r_count - c_cnt_one;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && w_push_ok) begin
            r_mem[r_wptr] <= w_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_ovalid      <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_w'(1);
            end
            if (w_row_done && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            r_count       <= w_count_nxt;
            r_ovalid      <= (w_count_nxt != '0);
            r_almost_full <= (w_count_nxt >= c_af_lvl);
        end
    end

    assign odata       = r_ovalid ? r_mem[r_rptr] : '0;
    assign ovalid      = r_ovalid;
    assign count       = r_count;
    assign almost_full = r_almost_full;
    assign overflow    = r_overflow;
    assign seq_err     = r_seq_err;

endmodule
`default_nettype wire
